// File: rtl/fir_pkg.sv
// Shared FIR stream types and width constants.
package fir_pkg;
  localparam int OUT_INTE_WL = 4;
  localparam int OUT_FRAC_WL = 8;
  localparam int DATA_WL     = OUT_INTE_WL + OUT_FRAC_WL;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} cap_state_t;
endpackage

// File: rtl/fir_capture_fifo.sv
// First-word-fall-through FIFO; occupancy tracked by count, pointers wrap naturally.
module fir_capture_fifo #(
  parameter int DATA_WL = 12,
  parameter int DEPTH   = 64,
  parameter int CNT_WL  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [DATA_WL-1:0] wr_data,
  output logic [DATA_WL-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [CNT_WL-1:0]  count
);
  localparam int PTR_WL = $clog2(DEPTH);

  logic [DATA_WL-1:0] mem_q [DEPTH];
  logic [PTR_WL-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WL-1:0]  count_q, count_d;

  assign full    = (count_q == CNT_WL'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  // Storage is not reset, so mask the head while empty to keep m_data at 0.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/fir_stream_capture.sv
// Capture buffer for the FIR valid-only output stream with ready/valid readout,
// burst tracking and sticky overflow.
module fir_stream_capture #(
  parameter int DATA_WL = fir_pkg::OUT_INTE_WL + fir_pkg::OUT_FRAC_WL,
  parameter int DEPTH   = 64,
  parameter int CNT_WL  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [DATA_WL-1:0] s_data,
  input  logic               s_valid,
  output logic [DATA_WL-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CNT_WL-1:0]  count,
  output logic [CNT_WL-1:0]  burst_len,
  output logic               burst_done,
  output logic               overflow
);
  import fir_pkg::*;

  cap_state_t        state_q, state_d;
  logic [CNT_WL-1:0] burst_len_q, burst_len_d;
  logic              burst_done_q, burst_done_d;
  logic              overflow_q, overflow_d;
  logic              full, empty, push, pop;

  // A same-cycle read frees a slot, so a full FIFO still takes the write.
  assign pop  = !empty && m_ready && !clear;
  assign push = s_valid && (!full || pop) && !clear;

  fir_capture_fifo #(.DATA_WL(DATA_WL), .DEPTH(DEPTH), .CNT_WL(CNT_WL)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .push    (push),
    .pop     (pop),
    .wr_data (s_data),
    .rd_data (m_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign m_valid    = !empty;
  assign burst_len  = burst_len_q;
  assign burst_done = burst_done_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d      = state_q;
    burst_len_d  = burst_len_q;
    burst_done_d = 1'b0;
    overflow_d   = overflow_q;
    if (clear) begin
      state_d     = IDLE;
      burst_len_d = '0;
      overflow_d  = 1'b0;
    end else begin
      if (s_valid && !push) overflow_d = 1'b1;
      case (state_q)
        IDLE, DRAIN: begin
          if (s_valid) begin
            state_d     = CAPTURE;
            burst_len_d = push ? CNT_WL'(1) : '0;
          end else if (state_q == DRAIN && empty) begin
            state_d = IDLE;
          end
        end
        CAPTURE: begin
          if (s_valid) begin
            if (push && burst_len_q != '1) burst_len_d = burst_len_q + 1'b1;
          end else begin
            burst_done_d = 1'b1;
            state_d      = DRAIN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      burst_len_q  <= '0;
      burst_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_len_q  <= burst_len_d;
      burst_done_q <= burst_done_d;
      overflow_q   <= overflow_d;
    end
  end
endmodule

// File: tb/tb_fir_stream_capture.sv
// Directed bench for fir_stream_capture: vector table for the basic burst,
// hand sequences for reset, overflow, full+read, back-to-back and clear.
module tb_fir_stream_capture;
  import fir_pkg::*;

  localparam int DW    = 12;
  localparam int DEPTH = 64;
  localparam int CW    = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] count, burst_len;
  logic          burst_done, overflow;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  fir_stream_capture #(.DATA_WL(DW), .DEPTH(DEPTH), .CNT_WL(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .s_data(s_data), .s_valid(s_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
    .burst_len(burst_len), .burst_done(burst_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
    logic          exp_valid;
    logic [CW-1:0] exp_count;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (burst_done) pulses++;
  endtask

  task automatic send(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
  endtask

  task automatic gap();
    s_valid = 1'b0;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    s_valid = 1'b0;
    step();
    clear = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_data"}, 32'(m_data), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_burst_len"}, 32'(burst_len), 0);
    chk({tag, "_burst_done"}, 32'(burst_done), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
  endtask

  initial begin
    vecs[0]  = '{12'h800, 12'h800, 1'b1, 7'd1};
    vecs[1]  = '{12'h001, 12'h001, 1'b1, 7'd1};
    vecs[2]  = '{12'hFFF, 12'hFFF, 1'b1, 7'd1};
    vecs[3]  = '{12'h064, 12'h064, 1'b1, 7'd1};
    vecs[4]  = '{12'h7FF, 12'h7FF, 1'b1, 7'd1};
    vecs[5]  = '{12'hF9C, 12'hF9C, 1'b1, 7'd1};
    vecs[6]  = '{12'h000, 12'h000, 1'b1, 7'd1};
    vecs[7]  = '{12'h005, 12'h005, 1'b1, 7'd1};
    vecs[8]  = '{12'hFFB, 12'hFFB, 1'b1, 7'd1};
    vecs[9]  = '{12'h4D2, 12'h4D2, 1'b1, 7'd1};
    vecs[10] = '{12'hB2E, 12'hB2E, 1'b1, 7'd1};
    vecs[11] = '{12'h0FF, 12'h0FF, 1'b1, 7'd1};
    vecs[12] = '{12'hF00, 12'hF00, 1'b1, 7'd1};
    vecs[13] = '{12'h007, 12'h007, 1'b1, 7'd1};
    vecs[14] = '{12'hFF9, 12'hFF9, 1'b1, 7'd1};

    // Reset state, then asynchronous reset in the middle of a burst
    #12;
    chk_zero("por");
    rst = 1'b1;
    step();
    for (int i = 0; i < 5; i++) send(12'(i + 1));
    chk("pre_rst_count", 32'(count), 5);
    #2 rst = 1'b0;
    #1;
    chk_zero("async_rst");
    s_valid = 1'b0;
    #3 rst = 1'b1;
    step();
    step();
    chk("post_rst_m_valid", 32'(m_valid), 0);
    chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));

    // Streaming burst with reader always ready
    m_ready = 1'b1;
    pulses = 0;
    foreach (vecs[i]) begin
      send(vecs[i].din);
      chk($sformatf("burst_data%0d", i), 32'(m_data), 32'(vecs[i].exp_dout));
      chk($sformatf("burst_valid%0d", i), 32'(m_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("burst_count%0d", i), 32'(count), 32'(vecs[i].exp_count));
    end
    chk("burst_done_early", 32'(pulses), 0);
    gap();
    chk("burst_done_pulse", 32'(burst_done), 1);
    chk("burst_len15", 32'(burst_len), 15);
    chk("burst_empty", 32'(m_valid), 0);
    gap();
    chk("burst_done_single", 32'(burst_done), 0);
    chk("burst_overflow", 32'(overflow), 0);
    chk("burst_state_idle", 32'(dut.state_q), 32'(IDLE));

    // Overflow: 70 samples, reader stalled
    m_ready = 1'b0;
    for (int i = 0; i < 70; i++) begin
      send(12'(i * 7 + 3));
      if (i == 63) chk("ovf_not_yet", 32'(overflow), 0);
      if (i == 64) chk("ovf_set", 32'(overflow), 1);
    end
    gap();
    chk("ovf_count", 32'(count), 64);
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_burst_len", 32'(burst_len), 64);
    m_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("ovf_rd%0d", k), 32'(m_data), 32'(12'(k * 7 + 3)));
      step();
    end
    chk("ovf_drained", 32'(m_valid), 0);
    chk("ovf_still_set", 32'(overflow), 1);

    // Full FIFO with a same-cycle read still accepts the write
    do_clear();
    chk("clr_ovf", 32'(overflow), 0);
    m_ready = 1'b0;
    for (int i = 0; i < 64; i++) send(12'(i + 100));
    chk("full_count", 32'(count), 64);
    m_ready = 1'b1;
    send(12'h555);
    chk("fullrd_count", 32'(count), 64);
    chk("fullrd_ovf", 32'(overflow), 0);
    chk("fullrd_head", 32'(m_data), 101);
    chk("fullrd_len", 32'(burst_len), 65);

    // Back-to-back bursts separated by one idle cycle
    do_clear();
    m_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) send(12'(i + 200));
    gap();
    chk("b2b_first_pulse", 32'(burst_done), 1);
    for (int i = 0; i < 5; i++) send(12'(i + 300));
    chk("b2b_len_mid", 32'(burst_len), 5);
    gap();
    gap();
    chk("b2b_pulses", 32'(pulses), 2);
    chk("b2b_len", 32'(burst_len), 5);
    chk("b2b_count", 32'(count), 15);
    chk("b2b_state_drain", 32'(dut.state_q), 32'(DRAIN));
    m_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("b2b_rd%0d", k), 32'(m_data), (k < 10) ? 32'(k + 200) : 32'(k - 10 + 300));
      step();
      if (k < 14) chk($sformatf("b2b_not_idle%0d", k), 32'(dut.state_q != IDLE), 1);
    end
    chk("b2b_state_last", 32'(dut.state_q), 32'(DRAIN));
    step();
    chk("b2b_state_idle", 32'(dut.state_q), 32'(IDLE));

    // Clear while filling wins over the same-cycle write
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) send(12'(i + 400));
    chk("clr_pre_count", 32'(count), 20);
    clear = 1'b1;
    send(12'h123);
    clear = 1'b0;
    chk_zero("clr");
    chk("clr_state", 32'(dut.state_q), 32'(IDLE));
    send(12'h321);
    chk("clr_restart_len", 32'(burst_len), 1);
    chk("clr_restart_count", 32'(count), 1);
    chk("clr_restart_data", 32'(m_data), 32'h321);
    gap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
